// File: rtl/adc_avg_pkg.sv
// Shared widths, CSR addresses and result record for the ADC sample averager.
// Pure definitions: no logic, no latency, no flow control.
package adc_avg_pkg;
    localparam int CH_W       = 5;
    localparam int SAMPLE_W   = 12;
    localparam int CSR_ADDR_W = 4;
    localparam int CSR_DATA_W = 16;

    localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_DROP_CNT = 4'd15;

    typedef struct packed {
        logic [CH_W-1:0]     channel;
        logic [SAMPLE_W-1:0] data;
    } avg_result_t;
endpackage

// File: rtl/adc_avg_channel_acc.sv
// One channel's running sum and sample count; result is combinational on the completing sample.
// No backpressure: every qualified sample is absorbed, and clear wins over a same-cycle sample.
module adc_avg_channel_acc
    import adc_avg_pkg::*;
#(
    parameter int LOG2_AVG = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clear,
    input  logic                i_sample_vld,
    input  logic [SAMPLE_W-1:0] i_sample_dat,
    output logic                o_result_vld,
    output logic [SAMPLE_W-1:0] o_result_dat
);
    localparam int ACC_W = SAMPLE_W + LOG2_AVG;
    localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] w_sum;
    logic             w_last;

    assign w_sum  = r_acc + ACC_W'(i_sample_dat);
    assign w_last = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_sample_vld) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // The top SAMPLE_W bits of the sum are the truncated average.
    assign o_result_vld = i_sample_vld && !i_clear && w_last;
    assign o_result_dat = w_sum[ACC_W-1 -: SAMPLE_W];
endmodule

// File: rtl/adc_sample_averager.sv
// Per-channel ADC averaging with a one-deep result stream and CSR latest-value readback; results appear 1 cycle after the completing sample.
// Results arriving while one is held and not accepted are dropped (counted when ADC_AVG_DROP_CNT_EN is defined); CSR reads return 1 cycle later.
module adc_sample_averager
    import adc_avg_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int LOG2_AVG = 3
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  in_valid,
    input  logic [CH_W-1:0]       in_channel,
    input  logic [SAMPLE_W-1:0]   in_data,
    input  logic                  clear,
    output logic                  avg_valid,
    input  logic                  avg_ready,
    output logic [CH_W-1:0]       avg_channel,
    output logic [SAMPLE_W-1:0]   avg_data,
    input  logic [CSR_ADDR_W-1:0] csr_address,
    input  logic                  csr_read,
    output logic [CSR_DATA_W-1:0] csr_readdata,
    output logic                  csr_readdatavalid
);
    logic [NUM_CH-1:0]   w_ch_done;
    logic [SAMPLE_W-1:0] w_ch_dat [NUM_CH];
    logic                w_res_vld;
    avg_result_t         w_res;
    logic                w_accept;
    logic [CSR_DATA_W-1:0] w_csr_dat;

    logic                r_avg_vld;
    avg_result_t         r_avg;
    logic [SAMPLE_W-1:0] r_latest [NUM_CH];
    logic                r_rd_vld;
    logic [CSR_DATA_W-1:0] r_rd_dat;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        adc_avg_channel_acc #(
            .LOG2_AVG (LOG2_AVG)
        ) u_acc (
            .i_clk        (clk_clk),
            .i_rst_n      (reset_reset_n),
            .i_clear      (clear),
            .i_sample_vld (in_valid && (in_channel == CH_W'(g))),
            .i_sample_dat (in_data),
            .o_result_vld (w_ch_done[g]),
            .o_result_dat (w_ch_dat[g])
        );
    end

    // At most one channel completes per cycle, so an OR-reduce selects its result.
    always_comb begin
        w_res_vld    = |w_ch_done;
        w_res.channel = in_channel;
        w_res.data    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch_done[i]) w_res.data = w_res.data | w_ch_dat[i];
        end
    end

    assign w_accept = !r_avg_vld || avg_ready;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_avg_vld <= 1'b0;
            r_avg     <= '0;
        end else if (w_res_vld && w_accept) begin
            r_avg_vld <= 1'b1;
            r_avg     <= w_res;
        end else if (r_avg_vld && avg_ready) begin
            r_avg_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!reset_reset_n)   r_latest[i] <= '0;
            else if (w_ch_done[i]) r_latest[i] <= w_ch_dat[i];
        end
    end

`ifdef ADC_AVG_DROP_CNT_EN
    logic [CSR_DATA_W-1:0] r_drop_cnt;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_drop_cnt <= '0;
        end else if (w_res_vld && !w_accept && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + CSR_DATA_W'(1);
        end
    end
`endif

    always_comb begin
        w_csr_dat = '0;
        if (csr_address == CSR_ADDR_DROP_CNT) begin
`ifdef ADC_AVG_DROP_CNT_EN
            w_csr_dat = r_drop_cnt;
`else
            w_csr_dat = '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (csr_address == CSR_ADDR_W'(i)) w_csr_dat = {4'b0, r_latest[i]};
            end
        end
    end

    // Registered read samples pre-edge state, so same-cycle updates are not visible.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_rd_vld <= 1'b0;
            r_rd_dat <= '0;
        end else begin
            r_rd_vld <= csr_read;
            r_rd_dat <= csr_read ? w_csr_dat : '0;
        end
    end

    assign avg_valid         = r_avg_vld;
    assign avg_channel       = r_avg.channel;
    assign avg_data          = r_avg.data;
    assign csr_readdata      = r_rd_dat;
    assign csr_readdatavalid = r_rd_vld;
endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager at default parameters.
// Drop-counter expectation follows ADC_AVG_DROP_CNT_EN.
module tb_adc_sample_averager;
`ifdef ADC_AVG_DROP_CNT_EN
    localparam int EXP_DROP = 1;
`else
    localparam int EXP_DROP = 0;
`endif

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        in_valid;
    logic [4:0]  in_channel;
    logic [11:0] in_data;
    logic        clear;
    logic        avg_valid;
    logic        avg_ready;
    logic [4:0]  avg_channel;
    logic [11:0] avg_data;
    logic [3:0]  csr_address;
    logic        csr_read;
    logic [15:0] csr_readdata;
    logic        csr_readdatavalid;

    int checks = 0;
    int failures = 0;

    adc_sample_averager dut (
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .in_valid          (in_valid),
        .in_channel        (in_channel),
        .in_data           (in_data),
        .clear             (clear),
        .avg_valid         (avg_valid),
        .avg_ready         (avg_ready),
        .avg_channel       (avg_channel),
        .avg_data          (avg_data),
        .csr_address       (csr_address),
        .csr_read          (csr_read),
        .csr_readdata      (csr_readdata),
        .csr_readdatavalid (csr_readdatavalid)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic        vld;
        logic [4:0]  ch;
        logic [11:0] dat;
        logic        clr;
        logic        rdy;
        logic        exp_vld;
        logic [4:0]  exp_ch;
        logic [11:0] exp_dat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic vld, input int ch, input int dat, input logic clr,
                                input logic rdy, input logic exp_vld, input int exp_ch,
                                input int exp_dat, input string name);
        vec_t v;
        v.vld = vld; v.ch = 5'(ch); v.dat = 12'(dat); v.clr = clr; v.rdy = rdy;
        v.exp_vld = exp_vld; v.exp_ch = 5'(exp_ch); v.exp_dat = 12'(exp_dat); v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input int ch, input int dat);
        in_valid = 1'b1;
        in_channel = 5'(ch);
        in_data = 12'(dat);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int addrs [4];
        int exps  [4];

        reset_reset_n = 1'b0;
        in_valid = 1'b0; in_channel = '0; in_data = '0; clear = 1'b0;
        avg_ready = 1'b1; csr_address = '0; csr_read = 1'b0;

        // Average of 100..107 is 103.5, truncated to 103.
        for (int i = 0; i < 8; i++) add(1, 2, 100 + i, 0, 1, i == 7, 2, 103, "ch2_avg");
        add(0, 0, 0, 0, 1, 0, 0, 0, "ch2_xfer");
        for (int i = 0; i < 16; i++)
            add(1, i % 2, (i % 2) ? 0 : 4095, 0, 1, i >= 14, i % 2, (i % 2) ? 0 : 4095, "ch01_interleave");
        add(0, 0, 0, 0, 1, 0, 0, 0, "ch01_xfer");
        for (int i = 0; i < 4; i++) add(1, 5, 1000, 0, 1, 0, 0, 0, "ch5_pre_clear");
        add(1, 5, 1000, 1, 1, 0, 0, 0, "ch5_clear");
        for (int i = 0; i < 8; i++) add(1, 5, 10, 0, 1, i == 7, 5, 10, "ch5_post_clear");
        add(0, 0, 0, 0, 1, 0, 0, 0, "ch5_xfer");

        tick();
        tick();
        chk("rst_avg_valid", avg_valid, 0);
        chk("rst_avg_channel", avg_channel, 0);
        chk("rst_avg_data", avg_data, 0);
        chk("rst_rdv", csr_readdatavalid, 0);
        chk("rst_rddata", csr_readdata, 0);
        reset_reset_n = 1'b1;
        tick();

        foreach (vecs[k]) begin
            in_valid = vecs[k].vld; in_channel = vecs[k].ch; in_data = vecs[k].dat;
            clear = vecs[k].clr; avg_ready = vecs[k].rdy;
            tick();
            chk({vecs[k].name, "_valid"}, avg_valid, vecs[k].exp_vld);
            if (vecs[k].exp_vld) begin
                chk({vecs[k].name, "_channel"}, avg_channel, vecs[k].exp_ch);
                chk({vecs[k].name, "_data"}, avg_data, vecs[k].exp_dat);
            end
        end
        in_valid = 1'b0; clear = 1'b0;

        // Held result with downstream stalled; a second ch3 result is dropped.
        avg_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(3, 200);
        chk("hold_first_valid", avg_valid, 1);
        chk("hold_first_data", avg_data, 200);
        for (int i = 0; i < 7; i++) send(3, 40);
        csr_read = 1'b1; csr_address = 4'd3;
        send(3, 40);
        chk("drop_held_valid", avg_valid, 1);
        chk("drop_held_channel", avg_channel, 3);
        chk("drop_held_data", avg_data, 200);
        chk("same_cycle_rd_rdv", csr_readdatavalid, 1);
        chk("same_cycle_rd_pre_update", csr_readdata, 200);
        tick();
        chk("latest_ch3", csr_readdata, 40);
        csr_address = 4'd15;
        tick();
        chk("drop_cnt", csr_readdata, EXP_DROP);
        csr_read = 1'b0; avg_ready = 1'b1;
        tick();
        chk("drop_xfer_valid", avg_valid, 0);
        chk("rd_idle_rdv", csr_readdatavalid, 0);

        // Back-to-back CSR reads.
        addrs = '{0, 1, 15, 9};
        exps  = '{4095, 0, EXP_DROP, 0};
        for (int i = 0; i < 4; i++) begin
            csr_read = 1'b1; csr_address = 4'(addrs[i]);
            tick();
            chk("b2b_rdv", csr_readdatavalid, 1);
            chk("b2b_rddata", csr_readdata, exps[i]);
        end
        csr_read = 1'b0;
        tick();
        chk("b2b_end_rdv", csr_readdatavalid, 0);
        chk("b2b_end_rddata", csr_readdata, 0);

        // Channels outside 0..NUM_CH-1 must not produce results or touch state.
        for (int i = 0; i < 8; i++) send(20, 4095);
        for (int i = 0; i < 8; i++) send(8, 4095);
        chk("oob_ch_no_result", avg_valid, 0);
        csr_read = 1'b1; csr_address = 4'd0;
        tick();
        chk("oob_ch0_intact", csr_readdata, 4095);
        csr_address = 4'd5;
        tick();
        chk("latest_ch5", csr_readdata, 10);
        csr_read = 1'b0;

        // Reset mid-accumulation with a held result and a read in the reset cycle.
        avg_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(4, 77);
        chk("pre_rst_held", avg_data, 77);
        for (int i = 0; i < 5; i++) send(0, 4000);
        reset_reset_n = 1'b0; csr_read = 1'b1; csr_address = 4'd4;
        tick();
        chk("mid_rst_avg_valid", avg_valid, 0);
        chk("mid_rst_avg_channel", avg_channel, 0);
        chk("mid_rst_avg_data", avg_data, 0);
        chk("mid_rst_rdv", csr_readdatavalid, 0);
        chk("mid_rst_rddata", csr_readdata, 0);
        reset_reset_n = 1'b1; avg_ready = 1'b1;
        tick();
        chk("post_rst_latest_ch4", csr_readdata, 0);
        csr_read = 1'b0;
        for (int i = 0; i < 7; i++) send(0, 8);
        chk("post_rst_no_early", avg_valid, 0);
        send(0, 8);
        chk("post_rst_valid", avg_valid, 1);
        chk("post_rst_channel", avg_channel, 0);
        chk("post_rst_data", avg_data, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_sample_averager.md
ADC_SAMPLE_AVERAGER -- requirements
Module: adc_sample_averager

Interface
REQ-001 Parameter NUM_CH, default 8, number of ADC channels tracked (channels 0..NUM_CH-1, max 16).
REQ-002 Parameter LOG2_AVG, default 3, averaging depth exponent (2^LOG2_AVG samples per result, range 0..4).
REQ-003 clk_clk  input  1  sole clock, all logic on rising edge.
REQ-004 reset_reset_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  ADC response sample valid (no backpressure toward ADC).
REQ-006 in_channel  input  5  ADC response channel number.
REQ-007 in_data  input  12  ADC response sample, unsigned.
REQ-008 clear  input  1  synchronous flush of all accumulators.
REQ-009 avg_valid  output  1  averaged result available.
REQ-010 avg_ready  input  1  downstream accepts result.
REQ-011 avg_channel  output  5  channel of averaged result.
REQ-012 avg_data  output  12  averaged value.
REQ-013 csr_address  input  4  CSR word address.
REQ-014 csr_read  input  1  CSR read strobe.
REQ-015 csr_readdata  output  16  CSR read data.
REQ-016 csr_readdatavalid  output  1  CSR read data qualifier.

Function
REQ-017 Per channel: accumulator (12+LOG2_AVG bits, no overflow possible) and sample counter (LOG2_AVG bits).
REQ-018 in_valid with in_channel >= NUM_CH: sample ignored, no state change.
REQ-019 Valid sample, counter < 2^LOG2_AVG-1: accumulator += in_data, counter += 1.
REQ-020 Valid sample, counter == 2^LOG2_AVG-1: result = (acc + in_data) >> LOG2_AVG (truncating), accumulator and counter return to 0 same cycle.
REQ-021 Result latency: result on avg_* and in latest-value register exactly 1 cycle after the completing sample.
REQ-022 Output handshake: avg_valid held with avg_channel/avg_data stable until avg_valid && avg_ready; transfer on that edge.
REQ-023 New result while avg_valid=1 and avg_ready=0: new result dropped from stream, held result unchanged.
REQ-024 New result while avg_valid=1 and avg_ready=1: held result transfers, new result loads, avg_valid stays 1.
REQ-025 Latest-value register of the channel always updated by every result, dropped or not.
REQ-026 clear=1: all accumulators and counters zeroed; a sample in the same cycle is discarded; avg_valid, held result and latest-value registers unaffected.
REQ-027 CSR read: csr_readdatavalid=1 exactly one cycle after csr_read=1, otherwise 0; back-to-back reads every cycle supported.
REQ-028 CSR map: address 0..NUM_CH-1 = {4'b0, latest average}; address 15 = drop counter (see REQ-033); other addresses read 0.
REQ-029 CSR read of a channel updated in the same cycle returns the pre-update value.

Reset
REQ-030 On reset_reset_n=0 at a clock edge: accumulators, counters, latest-value registers, drop counter cleared to 0.
REQ-031 Reset outputs: avg_valid=0, avg_channel=0, avg_data=0, csr_readdatavalid=0, csr_readdata=0.
REQ-032 Reset mid-accumulation discards partial sums; a read issued in the reset cycle returns no readdatavalid.

Configuration
REQ-033 Macro ADC_AVG_DROP_CNT_EN defined: 16-bit drop counter increments on each REQ-023 drop, saturates at 16'hFFFF, read at address 15; undefined: no counter logic, address 15 reads 0.

Structure
REQ-034 Shared package adc_avg_pkg: CSR address constants (CSR_ADDR_DROP_CNT=15), channel width 5, sample width 12, result struct {channel, data}.
REQ-035 One sub-module adc_avg_channel_acc: single-channel accumulator/counter, instantiated NUM_CH times.

Verification
REQ-036 Defaults, channel 2 samples 100,101,...,107 consecutive -> one result cycle after 8th: avg_channel=2, avg_data=103.
REQ-037 Interleaved channels 0/1, ch0 eight samples 4095, ch1 eight samples 0 -> results 4095 and 0, no cross-contamination.
REQ-038 avg_ready=0, two channel-3 averages complete -> first held, second dropped, CSR addr 3 holds second, addr 15 reads 1 (macro on) / 0 (off).
REQ-039 Four ch5 samples, clear pulse with a fifth sample same cycle, then eight samples of 10 -> single result 10.
REQ-040 csr_read on addresses 0,1,15,9 in consecutive cycles -> four readdatavalid pulses one cycle delayed, addr 9 returns 0; sample on channel 20 -> no state change.
REQ-041 Reset asserted after 5 ch0 samples -> all outputs 0; next 8 samples of 8 -> result 8.
